alu_arbiter: RTL and testbench

//  Shares one instance of the team's combinational 4-bit alu between two requesters.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/alu_arb_if.sv | 22 ++
 rtl/alu_arbiter_alu.sv | 26 ++
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcode, state and latency definitions for the alu arbiter
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  // Illegal opcodes still take one EXEC cycle so the error response is uniform.
  function automatic logic [3:0] op_lat(input logic [3:0] op, input int unsigned muldiv_lat);
    logic [31:0] w_lat;
    w_lat = muldiv_lat;
    return ((op == OP_MUL) || (op == OP_DIV)) ? w_lat[3:0] : 4'd1;
  endfunction

endpackage

// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - one requester's request/response channel pair
interface alu_arb_if;
  logic       valid;
  logic       ready;
  logic [3:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;

  modport master (
    output valid, op, a, b, rsp_ready,
    input  ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  valid, op, a, b, rsp_ready,
    output ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 4-bit alu, results modulo 16
module alu_arbiter_alu
  import alu_arb_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_MUL:  o_y = i_a * i_b;
      OP_DIV:  o_y = (i_b == '0) ? '0 : i_a / i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOT:  o_y = ~i_a;
      OP_OR:   o_y = i_a | i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one alu between two requesters
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  alu_arb_if.slave   r0,
  alu_arb_if.slave   r1,
  output logic       o_busy,
  output logic       o_grant_id
);

  logic [1:0] r_state;
  logic       r_rr_ptr;
  logic       r_owner;
  logic [3:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_cnt;
  logic [3:0] r_data;
  logic       r_err;

  logic       w_winner;
  logic       w_grant;
  logic       w_rsp_ready;
  logic [3:0] w_win_op;
  logic [3:0] w_alu_y;
  logic [3:0] w_res_data;
  logic       w_res_err;

  always_comb begin
    w_winner = r_rr_ptr;
    if (r0.valid && !r1.valid)      w_winner = 1'b0;
    else if (!r0.valid && r1.valid) w_winner = 1'b1;
  end

  assign w_grant     = (r_state == S_IDLE) && (r0.valid || r1.valid);
  assign r0.ready    = w_grant && !w_winner;
  assign r1.ready    = w_grant && w_winner;
  assign w_win_op    = w_winner ? r1.op : r0.op;
  assign w_rsp_ready = r_owner ? r1.rsp_ready : r0.rsp_ready;

  assign r0.rsp_valid = (r_state == S_RESP) && !r_owner;
  assign r1.rsp_valid = (r_state == S_RESP) && r_owner;
  assign r0.rsp_data  = r_data;
  assign r1.rsp_data  = r_data;
  assign r0.rsp_err   = r_err;
  assign r1.rsp_err   = r_err;
  assign o_busy       = (r_state != S_IDLE);
  assign o_grant_id   = r_owner;

  alu_arbiter_alu u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  // Divide by zero overrides whatever the alu produces.
  always_comb begin
    w_res_data = w_alu_y;
    w_res_err  = 1'b0;
    if (!op_legal(r_op) || ((r_op == OP_DIV) && (r_b == '0))) begin
      w_res_data = '0;
      w_res_err  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_op    <= w_win_op;
            r_a     <= w_winner ? r1.a : r0.a;
            r_b     <= w_winner ? r1.b : r0.b;
            r_cnt   <= op_lat(w_win_op, MULDIV_LAT) - 4'd1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_data  <= w_res_data;
            r_err   <= w_res_err;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_rr_ptr <= ~r_owner;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural model
module tb_alu_arbiter;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  logic busy;
  logic grant_id;
  int   checks;
  int   failures;
  bit   m_rr;

  alu_arb_if u_r0 ();
  alu_arb_if u_r1 ();

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .r0         (u_r0),
    .r1         (u_r1),
    .o_busy     (busy),
    .o_grant_id (grant_id)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] d, output bit e);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    d = 4'h0;
    e = 1'b0;
    case (int'(op))
      1: d = 4'((ia + ib) % 16);
      2: d = 4'((ia - ib + 16) % 16);
      3: d = 4'((ia * ib) % 16);
      4: if (ib == 0) e = 1'b1; else d = 4'(ia / ib);
      5: d = a & b;
      6: d = a ^ b;
      7: d = 4'(15 - ia);
      8: d = a | b;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    u_r0.valid = 1'b0; u_r1.valid = 1'b0;
    u_r0.rsp_ready = 1'b0; u_r1.rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives a single request on port n and observes its grant and response timing.
  task automatic run_op(input bit n, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int rdy_cyc, output int rsp_cyc, output int busy_cnt,
                        output logic [3:0] data, output bit err, output bit to);
    to = 1'b1; rdy_cyc = -1; rsp_cyc = -1; busy_cnt = 0; data = 4'h0; err = 1'b0;
    @(negedge clk);
    if (n) begin u_r1.valid = 1'b1; u_r1.op = op; u_r1.a = a; u_r1.b = b; u_r1.rsp_ready = 1'b1; end
    else   begin u_r0.valid = 1'b1; u_r0.op = op; u_r0.a = a; u_r0.b = b; u_r0.rsp_ready = 1'b1; end
    for (int c = 0; c < 60; c++) begin
      #1;
      if (busy) busy_cnt++;
      if ((n ? u_r1.ready : u_r0.ready) && rdy_cyc < 0) rdy_cyc = c;
      if (n ? u_r1.rsp_valid : u_r0.rsp_valid) begin
        rsp_cyc = c; to = 1'b0;
        data = n ? u_r1.rsp_data : u_r0.rsp_data;
        err  = n ? u_r1.rsp_err : u_r0.rsp_err;
      end
      @(negedge clk);
      if (rdy_cyc == c) begin if (n) u_r1.valid = 1'b0; else u_r0.valid = 1'b0; end
      if (!to) break;
    end
    u_r0.rsp_ready = 1'b0; u_r1.rsp_ready = 1'b0;
  endtask

  // Presents requests on either or both ports at once and records responses in order.
  task automatic run_pair(input bit v0, input bit v1,
                          input logic [3:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                          output int n_rsp, output bit own [2], output logic [3:0] dat [2],
                          output bit er [2], output int dual);
    bit g0;
    bit g1;
    int want;
    want = int'(v0) + int'(v1);
    n_rsp = 0; dual = 0;
    own = '{1'b0, 1'b0}; dat = '{4'h0, 4'h0}; er = '{1'b0, 1'b0};
    @(negedge clk);
    u_r0.valid = v0; u_r0.op = op0; u_r0.a = a0; u_r0.b = b0; u_r0.rsp_ready = 1'b1;
    u_r1.valid = v1; u_r1.op = op1; u_r1.a = a1; u_r1.b = b1; u_r1.rsp_ready = 1'b1;
    for (int c = 0; c < 100 && n_rsp < want; c++) begin
      #1;
      g0 = u_r0.ready; g1 = u_r1.ready;
      if ((g0 && g1) || (u_r0.rsp_valid && u_r1.rsp_valid)) dual++;
      if (u_r0.rsp_valid || u_r1.rsp_valid) begin
        if (n_rsp < 2) begin
          own[n_rsp] = u_r1.rsp_valid;
          dat[n_rsp] = u_r1.rsp_valid ? u_r1.rsp_data : u_r0.rsp_data;
          er[n_rsp]  = u_r1.rsp_valid ? u_r1.rsp_err : u_r0.rsp_err;
        end
        n_rsp++;
      end
      @(negedge clk);
      if (g0) u_r0.valid = 1'b0;
      if (g1) u_r1.valid = 1'b0;
    end
    u_r0.valid = 1'b0; u_r1.valid = 1'b0;
    u_r0.rsp_ready = 1'b0; u_r1.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({busy, grant_id, u_r0.ready, u_r1.ready, u_r0.rsp_valid, u_r1.rsp_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {busy, grant_id, u_r0.ready, u_r1.ready, u_r0.rsp_valid, u_r1.rsp_valid});
    end
    checks++;
    if ({u_r0.rsp_data, u_r0.rsp_err, u_r1.rsp_data, u_r1.rsp_err} !== 10'b0) begin
      failures++;
      $display("FAIL reset_data got=%h/%b want=0/0", u_r0.rsp_data, u_r0.rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int rc; int pc; int bc; logic [3:0] d; bit e; bit to;
    run_op(1'b0, 4'd1, 4'd7, 4'd9, rc, pc, bc, d, e, to);
    checks++;
    if (to || rc !== 0 || pc !== 2 || bc !== 2) begin
      failures++;
      $display("FAIL single_timing got ready=%0d rsp=%0d busy=%0d to=%0b want 0/2/2/0", rc, pc, bc, to);
    end
    checks++;
    if (d !== 4'h0 || e !== 1'b0) begin
      failures++;
      $display("FAIL single_data got=%h err=%b want=0 err=0", d, e);
    end
  endtask

  task automatic test_round_robin();
    int n; bit own [2]; logic [3:0] dat [2]; bit er [2]; int dual;
    pulse_reset();
    run_pair(1'b1, 1'b1, 4'd6, 4'd5, 4'd3, 4'd2, 4'd2, 4'd3, n, own, dat, er, dual);
    checks++;
    if (n !== 2 || own[0] !== 1'b0 || own[1] !== 1'b1 || dual !== 0) begin
      failures++;
      $display("FAIL rr_order got n=%0d own=%b%b dual=%0d want n=2 own=01 dual=0", n, own[0], own[1], dual);
    end
    checks++;
    if (dat[0] !== 4'h6 || dat[1] !== 4'hF || er[0] !== 1'b0 || er[1] !== 1'b0) begin
      failures++;
      $display("FAIL rr_data got=%h,%h err=%b%b want=6,f err=00", dat[0], dat[1], er[0], er[1]);
    end
    run_pair(1'b1, 1'b1, 4'd5, 4'd9, 4'd3, 4'd8, 4'd4, 4'd1, n, own, dat, er, dual);
    checks++;
    if (n !== 2 || own[0] !== 1'b0 || dat[0] !== 4'h1 || dat[1] !== 4'h5) begin
      failures++;
      $display("FAIL rr_again got n=%0d first=%b data=%h,%h want n=2 first=0 data=1,5", n, own[0], dat[0], dat[1]);
    end
  endtask

  task automatic test_mul();
    int rc; int pc; int bc; logic [3:0] d; bit e; bit to;
    run_op(1'b1, 4'd3, 4'd6, 4'd3, rc, pc, bc, d, e, to);
    checks++;
    if (to || pc !== LAT + 1 || d !== 4'h2 || e !== 1'b0) begin
      failures++;
      $display("FAIL mul got rsp=%0d data=%h err=%b to=%0b want rsp=%0d data=2 err=0", pc, d, e, to, LAT + 1);
    end
  endtask

  task automatic test_errors();
    logic [3:0] ops [3];
    int         lats [3];
    int rc; int pc; int bc; logic [3:0] d; bit e; bit to;
    ops = '{4'd4, 4'd0, 4'd12};
    lats = '{LAT + 1, 2, 2};
    for (int i = 0; i < 3; i++) begin
      run_op(1'(i % 2), ops[i], 4'd9, 4'd0, rc, pc, bc, d, e, to);
      checks++;
      if (to || pc !== lats[i] || d !== 4'h0 || e !== 1'b1) begin
        failures++;
        $display("FAIL err_op%0d got rsp=%0d data=%h err=%b want rsp=%0d data=0 err=1", ops[i], pc, d, e, lats[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bit got;
    bad = 0;
    @(negedge clk);
    u_r0.valid = 1'b1; u_r0.op = 4'd1; u_r0.a = 4'd3; u_r0.b = 4'd4; u_r0.rsp_ready = 1'b0;
    @(negedge clk);
    u_r0.valid = 1'b0;
    u_r1.valid = 1'b1; u_r1.op = 4'd5; u_r1.a = 4'hF; u_r1.b = 4'h6; u_r1.rsp_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (!u_r0.rsp_valid || u_r0.rsp_data !== 4'h7 || u_r1.ready || u_r1.rsp_valid) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_rsp got %0d bad cycles want 0", bad);
    end
    u_r0.rsp_ready = 1'b1; #1;
    checks++;
    if (u_r1.ready !== 1'b0 || u_r0.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL hs_cycle got r1_ready=%b r0_rsp_valid=%b want 0/1", u_r1.ready, u_r0.rsp_valid);
    end
    @(negedge clk);
    u_r0.rsp_ready = 1'b0; #1;
    checks++;
    if (u_r1.ready !== 1'b1 || u_r0.rsp_valid !== 1'b0 || u_r0.rsp_data !== 4'h7) begin
      failures++;
      $display("FAIL r1_grant got r1_ready=%b r0_rsp_valid=%b data=%h want 1/0/7",
               u_r1.ready, u_r0.rsp_valid, u_r0.rsp_data);
    end
    @(negedge clk);
    u_r1.valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (u_r1.rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || u_r1.rsp_data !== 4'h6 || u_r1.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL r1_after got seen=%b data=%h want seen=1 data=6", got, u_r1.rsp_data);
    end
    @(negedge clk);
    u_r1.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    int rc; int pc; int bc; logic [3:0] d; bit e; bit to;
    seen = 0;
    @(negedge clk);
    u_r0.valid = 1'b1; u_r0.op = 4'd1; u_r0.a = 4'd1; u_r0.b = 4'd1; u_r0.rsp_ready = 1'b1;
    @(negedge clk);
    u_r0.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({busy, grant_id, u_r0.rsp_valid, u_r1.rsp_valid, u_r0.rsp_data, u_r0.rsp_err} !== 9'b0) begin
      failures++;
      $display("FAIL midreset_state got busy=%b gid=%b rv=%b%b data=%h err=%b want all 0",
               busy, grant_id, u_r0.rsp_valid, u_r1.rsp_valid, u_r0.rsp_data, u_r0.rsp_err);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (u_r0.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midreset_norsp got %0d rsp cycles want 0", seen);
    end
    u_r0.rsp_ready = 1'b0;
    run_op(1'b1, 4'd8, 4'd5, 4'hA, rc, pc, bc, d, e, to);
    checks++;
    if (to || rc !== 0 || pc !== 2 || d !== 4'hF || e !== 1'b0) begin
      failures++;
      $display("FAIL midreset_fresh got ready=%0d rsp=%0d data=%h err=%b want 0/2/f/0", rc, pc, d, e);
    end
  endtask

  task automatic test_random();
    int n; bit own [2]; logic [3:0] dat [2]; bit er [2]; int dual;
    bit v0; bit v1; int want;
    logic [3:0] op [2]; logic [3:0] a [2]; logic [3:0] b [2];
    bit eo [2]; logic [3:0] ed [2]; bit ee [2];
    bit bad;
    pulse_reset();
    m_rr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      for (int k = 0; k < 2; k++) begin
        op[k] = 4'($urandom_range(0, 15));
        a[k]  = 4'($urandom_range(0, 15));
        b[k]  = 4'($urandom_range(0, 15));
      end
      if (v0 && v1) begin eo[0] = m_rr; eo[1] = ~m_rr; want = 2; end
      else begin eo[0] = v1; eo[1] = v1; want = 1; end
      for (int k = 0; k < want; k++) model(op[eo[k]], a[eo[k]], b[eo[k]], ed[k], ee[k]);
      m_rr = ~eo[want - 1];
      run_pair(v0, v1, op[0], a[0], b[0], op[1], a[1], b[1], n, own, dat, er, dual);
      bad = (n !== want) || (dual !== 0);
      for (int k = 0; k < want; k++)
        if (own[k] !== eo[k] || dat[k] !== ed[k] || er[k] !== ee[k]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL rand_%0d got n=%0d own=%b%b data=%h,%h err=%b%b dual=%0d want n=%0d own=%b%b data=%h,%h err=%b%b",
                 it, n, own[0], own[1], dat[0], dat[1], er[0], er[1], dual,
                 want, eo[0], eo[1], ed[0], ed[1], ee[0], ee[1]);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    failures = 0;
    u_r0.valid = 1'b0; u_r0.op = 4'h0; u_r0.a = 4'h0; u_r0.b = 4'h0; u_r0.rsp_ready = 1'b0;
    u_r1.valid = 1'b0; u_r1.op = 4'h0; u_r1.a = 4'h0; u_r1.b = 4'h0; u_r1.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_mul();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
